// File: rtl/snp_req_initiator.sv
// Bus-side snoop initiator: broadcasts one coherence request to every non-excluded peer,
// gathers one response per peer and reports the aggregate to the arbiter.
module snp_req_initiator #(
    parameter int NUM_PEERS  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PEERS-1:0]   req_excl,
    output logic [NUM_PEERS-1:0]   snp_valid,
    input  logic [NUM_PEERS-1:0]   snp_ready,
    output logic [1:0]             snp_op,
    output logic [ADDR_WIDTH-1:0]  snp_addr,
    input  logic [NUM_PEERS-1:0]   rsp_valid,
    input  logic [2*NUM_PEERS-1:0] rsp,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic                   done_hit,
    output logic [NUM_PEERS-1:0]   done_hit_mask,
    output logic                   done_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // cache_pkg encodings: SUREQ_RD=0, SUREQ_RFO=1, SUREQ_INV=2; SDRSP_OKAY=0, SDRSP_INV=1
    localparam logic [1:0] SUREQ_INV  = 2'd2;
    localparam logic [1:0] SDRSP_OKAY = 2'd0;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [NUM_PEERS-1:0]    pend_snd, pend_snd_nxt;
    logic [NUM_PEERS-1:0]    pend_rsp, pend_rsp_nxt;
    logic [NUM_PEERS-1:0]    hit_mask, hit_mask_nxt;
    logic [1:0]              op, op_nxt;
    logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
    logic [TW-1:0]           timer, timer_nxt;
    logic                    timed_out, timed_out_nxt;

    logic [NUM_PEERS-1:0]    targets;
    logic [NUM_PEERS-1:0]    handshake;
    logic [NUM_PEERS-1:0]    rsp_acc;
    logic [NUM_PEERS-1:0]    rsp_okay;

    assign targets   = ~req_excl;
    assign snp_valid = (state == SEND) ? pend_snd : '0;
    assign handshake = snp_valid & snp_ready;

    // A response only counts once its snoop has been handed over (or in the same cycle).
    always_comb begin
        rsp_acc  = '0;
        rsp_okay = '0;
        for (int i = 0; i < NUM_PEERS; i++) begin
            rsp_okay[i] = (rsp[2*i +: 2] == SDRSP_OKAY);
            rsp_acc[i]  = rsp_valid[i] & pend_rsp[i] & (~pend_snd[i] | handshake[i]);
        end
    end

    always_comb begin
        state_nxt     = state;
        pend_snd_nxt  = pend_snd;
        pend_rsp_nxt  = pend_rsp;
        hit_mask_nxt  = hit_mask;
        op_nxt        = op;
        addr_nxt      = addr;
        timer_nxt     = timer;
        timed_out_nxt = timed_out;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_nxt        = req_op;
                    addr_nxt      = req_addr;
                    pend_snd_nxt  = targets;
                    pend_rsp_nxt  = targets;
                    hit_mask_nxt  = '0;
                    timer_nxt     = '0;
                    timed_out_nxt = 1'b0;
                    state_nxt     = (targets == '0) ? DONE : SEND;
                end
            end
            SEND, WAIT: begin
                pend_snd_nxt = pend_snd & ~handshake;
                pend_rsp_nxt = pend_rsp & ~rsp_acc;
                hit_mask_nxt = hit_mask | (rsp_acc & rsp_okay);
                timer_nxt    = timer + TW'(1);
                // Completion takes priority over a timeout expiring in the same cycle.
                if (pend_snd_nxt == '0 && pend_rsp_nxt == '0) begin
                    state_nxt = DONE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nxt     = DONE;
                    timed_out_nxt = 1'b1;
                end else if (pend_snd_nxt == '0) begin
                    state_nxt = WAIT;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_snd  <= '0;
            pend_rsp  <= '0;
            hit_mask  <= '0;
            op        <= '0;
            addr      <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend_snd  <= pend_snd_nxt;
            pend_rsp  <= pend_rsp_nxt;
            hit_mask  <= hit_mask_nxt;
            op        <= op_nxt;
            addr      <= addr_nxt;
            timer     <= timer_nxt;
            timed_out <= timed_out_nxt;
        end
    end

    assign req_ready     = (state == IDLE);
    assign done_valid    = (state == DONE);
    assign snp_op        = op;
    assign snp_addr      = addr;
    assign done_hit      = done_valid & (|hit_mask) & (op != SUREQ_INV);
    assign done_hit_mask = done_valid ? hit_mask : '0;
    assign done_timeout  = done_valid & timed_out;

endmodule

// File: tb/tb_snp_req_initiator.sv
// Self-checking bench for snp_req_initiator: directed scenarios plus randomized peer schedules
// checked against a schedule-level model of when each peer's response lands.
module tb_snp_req_initiator;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int TO = 8;
    localparam int NEVER = 1000000;

    localparam logic [1:0] SUREQ_RD   = 2'd0;
    localparam logic [1:0] SUREQ_RFO  = 2'd1;
    localparam logic [1:0] SUREQ_INV  = 2'd2;
    localparam logic [1:0] SDRSP_OKAY = 2'd0;
    localparam logic [1:0] SDRSP_INV  = 2'd1;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [AW-1:0]   req_addr;
    logic [NP-1:0]   req_excl;
    logic [NP-1:0]   snp_valid;
    logic [NP-1:0]   snp_ready;
    logic [1:0]      snp_op;
    logic [AW-1:0]   snp_addr;
    logic [NP-1:0]   rsp_valid;
    logic [2*NP-1:0] rsp;
    logic            done_valid;
    logic            done_ready;
    logic            done_hit;
    logic [NP-1:0]   done_hit_mask;
    logic            done_timeout;

    snp_req_initiator #(.NUM_PEERS(NP), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_excl(req_excl),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .rsp_valid(rsp_valid), .rsp(rsp),
        .done_valid(done_valid), .done_ready(done_ready), .done_hit(done_hit),
        .done_hit_mask(done_hit_mask), .done_timeout(done_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-peer schedule, in cycles counted from the first SEND cycle.
    int         dly [NP];
    int         lag [NP];
    bit         nores [NP];
    logic [1:0] code [NP];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setPeer(input int i, input int d, input int l, input bit nr, input logic [1:0] cd);
        dly[i] = d; lag[i] = l; nores[i] = nr; code[i] = cd;
    endtask

    task automatic randomPeers();
        for (int i = 0; i < NP; i++)
            setPeer(i, $urandom_range(0, 5), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                    2'($urandom_range(0, 3)));
    endtask

    // Completion cycle is one past the last response; anything past TO-1 becomes a timeout.
    task automatic model(input logic [NP-1:0] excl, input logic [1:0] op, output int e,
                         output logic [NP-1:0] m, output logic to, output logic hit);
        logic [NP-1:0] tg;
        int last, rc;
        tg = ~excl; last = -1; m = '0; to = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (tg[i]) begin
                rc = nores[i] ? NEVER : dly[i] + lag[i];
                if (rc > last) last = rc;
                if (!nores[i] && code[i] == SDRSP_OKAY && rc <= TO - 1) m[i] = 1'b1;
            end
        end
        if (tg == '0) e = 0;
        else if (last <= TO - 1) e = last + 1;
        else begin e = TO; to = 1'b1; end
        hit = (m != '0) && (op != SUREQ_INV);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr,
                                 input logic [NP-1:0] excl, input int hold);
        int e;
        logic [NP-1:0] em, ev, tg;
        logic eto, ehit;
        model(excl, op, e, em, eto, ehit);
        tg = ~excl;
        @(negedge clk);
        checkOutput("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_excl = excl;
        for (int c = 0; c <= e; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_op    = 2'($urandom);
            req_addr  = $urandom;
            rsp_valid = '0;
            rsp       = '0;
            if (c < e) begin
                for (int i = 0; i < NP; i++) ev[i] = tg[i] && (c <= dly[i]);
                checkOutput("busy_done_valid", done_valid, 0);
                checkOutput("busy_req_ready", req_ready, 0);
                checkOutput("snp_valid", snp_valid, ev);
                checkOutput("snp_op", snp_op, op);
                checkOutput("snp_addr", snp_addr, addr);
                for (int i = 0; i < NP; i++) begin
                    if (tg[i]) begin
                        snp_ready[i] = (c >= dly[i]);
                        if (!nores[i] && c == dly[i] + lag[i]) begin
                            rsp_valid[i] = 1'b1; rsp[2*i +: 2] = code[i];
                        end else if ((c < dly[i] || (!nores[i] && c > dly[i] + lag[i]))
                                     && $urandom_range(0, 3) == 0) begin
                            rsp_valid[i] = 1'b1; rsp[2*i +: 2] = SDRSP_OKAY;
                        end
                    end else begin
                        snp_ready[i] = 1'($urandom);
                        rsp_valid[i] = 1'($urandom);
                        rsp[2*i +: 2] = SDRSP_OKAY;
                    end
                end
            end else begin
                snp_ready = '0;
                checkOutput("done_valid", done_valid, 1);
                checkOutput("done_hit", done_hit, ehit);
                checkOutput("done_hit_mask", done_hit_mask, em);
                checkOutput("done_timeout", done_timeout, eto);
                checkOutput("done_snp_valid", snp_valid, 0);
                checkOutput("done_req_ready", req_ready, 0);
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checkOutput("hold_done_valid", done_valid, 1);
            checkOutput("hold_hit", done_hit, ehit);
            checkOutput("hold_mask", done_hit_mask, em);
            checkOutput("hold_timeout", done_timeout, eto);
            checkOutput("hold_req_ready", req_ready, 0);
        end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        checkOutput("after_done_valid", done_valid, 0);
        checkOutput("after_req_ready", req_ready, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, req_ready, 1);
        checkOutput({tag, "_snp_valid"}, snp_valid, 0);
        checkOutput({tag, "_snp_op"}, snp_op, 0);
        checkOutput({tag, "_snp_addr"}, snp_addr, 0);
        checkOutput({tag, "_done_valid"}, done_valid, 0);
        checkOutput({tag, "_done_hit"}, done_hit, 0);
        checkOutput({tag, "_done_mask"}, done_hit_mask, 0);
        checkOutput({tag, "_done_timeout"}, done_timeout, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_excl = '0;
        snp_ready = '0; rsp_valid = '0; rsp = '0; done_ready = 1'b0;
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Peers 1 and 2 ready at once; peer 2 OKAY, peer 1 INV.
        setPeer(0, 0, 0, 0, SDRSP_OKAY);
        setPeer(1, 0, 0, 0, SDRSP_INV);
        setPeer(2, 0, 0, 0, SDRSP_OKAY);
        applyStimulus(SUREQ_RD, 32'h0000_1040, 3'b001, 0);

        // Staggered snoop acceptance: peer 2 only after 4 cycles.
        setPeer(1, 0, 1, 0, SDRSP_INV);
        setPeer(2, 4, 1, 0, SDRSP_INV);
        applyStimulus(SUREQ_RFO, 32'hDEAD_BEC0, 3'b001, 1);

        // Invalidate with an OKAY response never reports a hit.
        setPeer(0, 1, 0, 0, SDRSP_OKAY);
        setPeer(1, 0, 2, 0, SDRSP_INV);
        applyStimulus(SUREQ_INV, 32'h0BAD_F00D, 3'b100, 0);

        // Peer 1 never responds: timeout after TO cycles in SEND/WAIT.
        setPeer(1, 0, 0, 1, SDRSP_OKAY);
        setPeer(2, 1, 0, 0, SDRSP_OKAY);
        applyStimulus(SUREQ_RD, 32'h1234_5678, 3'b001, 0);

        // Nobody to snoop: immediate completion, then held without done_ready.
        applyStimulus(SUREQ_RFO, 32'hCAFE_0000, 3'b111, 5);

        // Reset asserted while waiting for responses.
        @(negedge clk);
        req_valid = 1'b1; req_op = SUREQ_RFO; req_addr = 32'h00AB_CD00; req_excl = 3'b001;
        @(negedge clk);
        req_valid = 1'b0; snp_ready = 3'b110;
        @(negedge clk);
        snp_ready = '0;
        checkOutput("wait_snp_addr", snp_addr, 32'h00AB_CD00);
        checkOutput("wait_snp_valid", snp_valid, 0);
        checkOutput("wait_req_ready", req_ready, 0);
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        setPeer(0, 0, 0, 0, SDRSP_OKAY);
        setPeer(1, 2, 0, 0, SDRSP_OKAY);
        setPeer(2, 0, 3, 0, SDRSP_INV);
        applyStimulus(SUREQ_RD, 32'h0000_0FC0, 3'b000, 0);

        for (int t = 0; t < 40; t++) begin
            randomPeers();
            applyStimulus(2'($urandom_range(0, 2)), $urandom, 3'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
